// File: rtl/sseg_pkg.sv
// -----------------------------------------------------------------------------
// sseg_pkg
// Definitions shared by the 7-segment encoder and the scan-capture receiver:
//   - GLYPH: the sixteen hex glyphs, active-high, bit0 = segment a ... bit6 = g
//   - scan_state_e: states of the per-sample digit-tracking FSM
//   - onehot_idx(): index of the single set bit of a 4-bit one-hot anode vector
// -----------------------------------------------------------------------------
package sseg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,  // no digit selected (blanking or multi-anode glitch)
    TRACK = 2'd1,  // digit selected, waiting for it to stay stable
    HELD  = 2'd2   // digit latched, waiting for the scan to move on
  } scan_state_e;

  // Glyphs 0-9, A, b, C, d, E, F.
  localparam logic [6:0] GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Only meaningful for a one-hot input; anything else maps to 0.
  function automatic logic [1:0] onehot_idx(input logic [3:0] oh);
    case (oh)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/sseg_to_hex.sv
// -----------------------------------------------------------------------------
// sseg_to_hex
// Combinational glyph decoder: active-high 7-segment pattern -> hex nibble.
// Ports:
//   seg_i     in  7  segment pattern, bit0 = a ... bit6 = g, 1 = lit
//   nibble_o  out 4  decoded hex value (0 when err_o or blank_o)
//   err_o     out 1  pattern is neither a hex glyph nor blank
//   blank_o   out 1  all segments off
// -----------------------------------------------------------------------------
module sseg_to_hex
  import sseg_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] nibble_o,
  output logic       err_o,
  output logic       blank_o
);

  always_comb begin
    // NOTE: every output gets a default before any branch; a path that leaves an
    // output unassigned in always_comb would infer a latch.
    nibble_o = 4'h0;
    err_o    = 1'b1;
    blank_o  = 1'b0;
    if (seg_i == 7'h00) begin
      err_o   = 1'b0;
      blank_o = 1'b1;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (seg_i == GLYPH[i]) begin
          nibble_o = 4'(i);
          err_o    = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/sseg_scan_capture.sv
// -----------------------------------------------------------------------------
// sseg_scan_capture
// Receiver for a multiplexed 4-digit 7-segment display. Synchronises the
// scanned lines, waits for each selected digit to settle, decodes it into a
// shadow slot and publishes all four digits together once every slot has been
// refreshed. stale_o flags that no complete frame arrived for TIMEOUT_CYC clocks.
// Ports:
//   clk          in  1   system clock
//   rst_n        in  1   asynchronous active-low reset
//   SSeg         in  7   segment lines, bit0 = a ... bit6 = g
//   an           in  4   anode lines, an[0] = rightmost digit
//   digits_o     out 16  {digit3, digit2, digit1, digit0}
//   err_o        out 4   per digit: unrecognised glyph (nibble is 0)
//   blank_o      out 4   per digit: all segments off (nibble is 0)
//   frame_valid  out 1   one-cycle pulse when the outputs update
//   stale_o      out 1   no complete frame within TIMEOUT_CYC clocks
// -----------------------------------------------------------------------------
module sseg_scan_capture
  import sseg_pkg::*;
#(
  parameter int STABLE_CYC     = 1000,
  parameter int TIMEOUT_CYC    = 2_000_000,
  parameter bit AN_ACTIVE_LOW  = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  SSeg,
  input  logic [3:0]  an,
  output logic [15:0] digits_o,
  output logic [3:0]  err_o,
  output logic [3:0]  blank_o,
  output logic        frame_valid,
  output logic        stale_o
);

  localparam int ST_W = $clog2(STABLE_CYC + 1);
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [ST_W-1:0] STABLE_LAST = ST_W'(STABLE_CYC - 1);
  localparam logic [TO_W-1:0] TIMEOUT_MAX = TO_W'(TIMEOUT_CYC);
  localparam logic [TO_W-1:0] TIMEOUT_PRE = TO_W'(TIMEOUT_CYC - 1);
  // Synchronisers reset to the "nothing lit" pin level.
  localparam logic [3:0] AN_OFF  = AN_ACTIVE_LOW  ? 4'hF  : 4'h0;
  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

  // ---------------------------------------------------------------- sync
  logic [6:0] seg_s1_q, seg_s2_q;
  logic [3:0] an_s1_q, an_s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_s1_q <= SEG_OFF;
      seg_s2_q <= SEG_OFF;
      an_s1_q  <= AN_OFF;
      an_s2_q  <= AN_OFF;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge value,
      // so the two stages really form a 2-cycle pipeline.
      seg_s1_q <= SSeg;
      seg_s2_q <= seg_s1_q;
      an_s1_q  <= an;
      an_s2_q  <= an_s1_q;
    end
  end

  // Active-high view of the synchronised sample.
  logic [3:0] an_hi;
  logic [6:0] seg_hi;
  logic       an_valid;

  assign an_hi    = an_s2_q  ^ {4{AN_ACTIVE_LOW}};
  assign seg_hi   = seg_s2_q ^ {7{SEG_ACTIVE_LOW}};
  assign an_valid = $onehot(an_hi);

  // ---------------------------------------------------------------- tracking FSM
  scan_state_e      state_q;
  logic [ST_W-1:0]  stab_cnt_q;
  logic [3:0]       cap_an_q;
  logic [6:0]       cap_seg_q;
  logic [3:0][3:0]  shadow_nib_q;
  logic [3:0]       shadow_err_q, shadow_blank_q;
  logic [3:0]       seen_q;

  logic       sample_eq, latch_en, frame_now;
  logic [3:0] dec_nib;
  logic       dec_err, dec_blank;
  logic [1:0] slot;

  assign sample_eq = ({an_hi, seg_hi} == {cap_an_q, cap_seg_q});
  // The STABLE_CYC-th identical sample in TRACK latches the digit.
  assign latch_en  = (state_q == TRACK) && sample_eq && (stab_cnt_q == STABLE_LAST);
  assign frame_now = (seen_q == 4'hF);
  assign slot      = onehot_idx(cap_an_q);

  sseg_to_hex u_dec (
    .seg_i    (cap_seg_q),
    .nibble_o (dec_nib),
    .err_o    (dec_err),
    .blank_o  (dec_blank)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      stab_cnt_q     <= '0;
      cap_an_q       <= '0;
      cap_seg_q      <= '0;
      // NOTE: the shadow slots are reset too, so nothing from before a reset can
      // ever resurface; they are only a few flops.
      shadow_nib_q   <= '0;
      shadow_err_q   <= '0;
      shadow_blank_q <= '0;
      seen_q         <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (an_valid) begin
            state_q    <= TRACK;
            stab_cnt_q <= ST_W'(1);
            cap_an_q   <= an_hi;
            cap_seg_q  <= seg_hi;
          end
        end
        TRACK, HELD: begin
          if (sample_eq) begin
            // HELD keeps the count at STABLE_CYC: no relatch, no wrap.
            if (state_q == TRACK) begin
              stab_cnt_q <= stab_cnt_q + ST_W'(1);
              if (latch_en) state_q <= HELD;
            end
          end else if (an_valid) begin
            state_q    <= TRACK;
            stab_cnt_q <= ST_W'(1);
            cap_an_q   <= an_hi;
            cap_seg_q  <= seg_hi;
          end else begin
            state_q    <= IDLE;
            stab_cnt_q <= '0;
          end
        end
        default: begin
          state_q    <= IDLE;
          stab_cnt_q <= '0;
        end
      endcase

      if (latch_en) begin
        shadow_nib_q[slot]   <= dec_nib;
        shadow_err_q[slot]   <= dec_err;
        shadow_blank_q[slot] <= dec_blank;
      end
      // A latch in the publishing cycle starts the next frame's mask.
      seen_q <= (frame_now ? 4'h0 : seen_q) | (latch_en ? cap_an_q : 4'h0);
    end
  end

  // ---------------------------------------------------------------- publish / timeout
  logic [TO_W-1:0] to_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits_o    <= '0;
      err_o       <= '0;
      blank_o     <= '0;
      frame_valid <= 1'b0;
      stale_o     <= 1'b1;
      to_cnt_q    <= '0;
    end else begin
      frame_valid <= frame_now;
      if (frame_now) begin
        // Frame completion beats a coincident timeout expiry.
        digits_o <= shadow_nib_q;
        err_o    <= shadow_err_q;
        blank_o  <= shadow_blank_q;
        stale_o  <= 1'b0;
        to_cnt_q <= '0;
      end else begin
        if (to_cnt_q != TIMEOUT_MAX) to_cnt_q <= to_cnt_q + TO_W'(1);
        if (to_cnt_q >= TIMEOUT_PRE) stale_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sseg_scan_capture.sv
// -----------------------------------------------------------------------------
// tb_sseg_scan_capture
// Drives scanned display patterns as (anode, glyph, duration) items. A model
// works on whole items: a run of identical selected-digit samples at least
// STABLE cycles long fills that digit's slot; four filled slots make a frame,
// which is queued. A monitor pops and compares on every frame_valid and tracks
// the expected stale_o level from elapsed time since the last frame.
// -----------------------------------------------------------------------------
module tb_sseg_scan_capture;

  localparam int STABLE  = 8;
  localparam int TIMEOUT = 200;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  SSeg;
  logic [3:0]  an;
  logic [15:0] digits_o;
  logic [3:0]  err_o, blank_o;
  logic        frame_valid, stale_o;

  always #5 clk = ~clk;

  sseg_scan_capture #(
    .STABLE_CYC     (STABLE),
    .TIMEOUT_CYC    (TIMEOUT),
    .AN_ACTIVE_LOW  (1'b1),
    .SEG_ACTIVE_LOW (1'b1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .SSeg        (SSeg),
    .an          (an),
    .digits_o    (digits_o),
    .err_o       (err_o),
    .blank_o     (blank_o),
    .frame_valid (frame_valid),
    .stale_o     (stale_o)
  );

  typedef struct {
    logic [15:0] digits;
    logic [3:0]  err;
    logic [3:0]  blank;
  } frame_t;

  frame_t exp_q[$];
  int checks   = 0;
  int failures = 0;

  // Standard hex glyphs, active-high, a = bit0.
  logic [6:0] hex_glyph [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  logic [3:0][3:0] m_nib;
  logic [3:0]      m_err, m_blank, m_seen;
  logic [10:0]     m_prev_key;
  int              m_run;
  bit              m_run_latched;

  task automatic model_reset();
    m_nib = '0; m_err = '0; m_blank = '0; m_seen = '0;
    m_prev_key = 11'h000;   // pins idle: nothing selected, nothing lit
    m_run = 0;
    m_run_latched = 1'b1;
  endtask

  task automatic model_latch(input logic [3:0] an_ah, input logic [6:0] seg_ah);
    int s;
    s = 0;
    for (int i = 0; i < 4; i++) if (an_ah[i]) s = i;
    m_nib[s] = 4'h0; m_err[s] = 1'b1; m_blank[s] = 1'b0;
    if (seg_ah == 7'h00) begin
      m_err[s] = 1'b0; m_blank[s] = 1'b1;
    end else begin
      for (int d = 0; d < 16; d++)
        if (hex_glyph[d] == seg_ah) begin m_nib[s] = 4'(d); m_err[s] = 1'b0; end
    end
    m_seen[s] = 1'b1;
    if (m_seen == 4'hF) begin
      exp_q.push_back('{digits: m_nib, err: m_err, blank: m_blank});
      m_seen = '0;
    end
  endtask

  // Present one pattern (active-high view) on the pins for n clocks.
  task automatic drive_item(input logic [3:0] an_ah, input logic [6:0] seg_ah, input int n);
    logic [10:0] key;
    key = {an_ah, seg_ah};
    if (key == m_prev_key) m_run += n;
    else begin m_run = n; m_run_latched = 1'b0; m_prev_key = key; end
    if ($onehot(an_ah) && !m_run_latched && m_run >= STABLE) begin
      model_latch(an_ah, seg_ah);
      m_run_latched = 1'b1;
    end
    an   = ~an_ah;
    SSeg = ~seg_ah;
    repeat (n) @(negedge clk);
  endtask

  // Scan digit0..digit3 (rightmost first), optional gap pattern between digits.
  task automatic scan4(input int d3, input int d2, input int d1, input int d0,
                       input int n, input logic [3:0] gap_an, input int gap_n);
    int v [4];
    v[0] = d0; v[1] = d1; v[2] = d2; v[3] = d3;
    for (int s = 0; s < 4; s++) begin
      drive_item(4'(1 << s), hex_glyph[v[s]], n);
      if (gap_n > 0) drive_item(gap_an, 7'h00, gap_n);
    end
  endtask

  // ---------------------------------------------------------------- monitor
  int     since_frame  = 0;
  bit     no_frame_yet = 1'b1;
  frame_t got_exp;

  always @(negedge clk) begin
    if (!rst_n) begin
      no_frame_yet = 1'b1;
      since_frame  = 0;
    end else if (frame_valid) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_frame: got digits=%h err=%b blank=%b with nothing expected",
                 digits_o, err_o, blank_o);
      end else begin
        got_exp = exp_q.pop_front();
        check("frame_digits", 32'(digits_o), 32'(got_exp.digits));
        check("frame_err",    32'(err_o),    32'(got_exp.err));
        check("frame_blank",  32'(blank_o),  32'(got_exp.blank));
      end
      check("stale_at_frame", 32'(stale_o), 32'd0);
      no_frame_yet = 1'b0;
      since_frame  = 0;
    end else begin
      since_frame++;
      if (no_frame_yet)                    check("stale_no_frame", 32'(stale_o), 32'd1);
      else if (since_frame < TIMEOUT - 4)  check("stale_fresh",    32'(stale_o), 32'd0);
      else if (since_frame > TIMEOUT + 4)  check("stale_timeout",  32'(stale_o), 32'd1);
    end
  end

  // ---------------------------------------------------------------- stimulus
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wait_cyc;
    int nfr;
    rst_n = 1'b0;
    an    = 4'hF;
    SSeg  = 7'h7F;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_digits", 32'(digits_o),    32'h0);
    check("rst_err",    32'(err_o),       32'h0);
    check("rst_blank",  32'(blank_o),     32'h0);
    check("rst_fv",     32'(frame_valid), 32'h0);
    check("rst_stale",  32'(stale_o),     32'h1);
    rst_n = 1'b1;
    drive_item(4'h0, 7'h00, 4);

    // 1: plain "1234", 20 clocks per digit.
    scan4(1, 2, 3, 4, 20, 4'h0, 0);
    drive_item(4'h0, 7'h00, 10);
    check("t1_stale_low", 32'(stale_o), 32'h0);

    // 2: digits too short to settle, long enough for the timeout.
    nfr = exp_q.size();
    for (int k = 0; k < 14; k++) scan4(5, 6, 7, 8, 6, 4'h0, 0);
    check("t2_no_frame_queued", 32'(exp_q.size()), 32'(nfr));
    check("t2_stale_high", 32'(stale_o), 32'h1);

    // 3: unrecognised glyph on digit2.
    drive_item(4'b0001, hex_glyph[4], 20);
    drive_item(4'b0010, hex_glyph[3], 20);
    drive_item(4'b0100, 7'b1010101,   20);
    drive_item(4'b1000, hex_glyph[1], 20);
    drive_item(4'h0, 7'h00, 10);

    // 4: blanking gaps, plus a single two-anode sample between digits.
    drive_item(4'b0001, hex_glyph[4], 20);
    drive_item(4'h0,    7'h00, 3);
    drive_item(4'b0010, hex_glyph[3], 20);
    drive_item(4'b0011, hex_glyph[8], 1);
    drive_item(4'b0100, hex_glyph[2], 20);
    drive_item(4'h0,    7'h00, 3);
    drive_item(4'b1000, hex_glyph[1], 20);
    drive_item(4'h0,    7'h00, 10);

    // 5: digit0 rewritten 4 -> 9 before the frame completes.
    drive_item(4'b0001, hex_glyph[4], 20);
    drive_item(4'b0010, hex_glyph[3], 20);
    drive_item(4'b0001, hex_glyph[9], 20);
    drive_item(4'b0100, hex_glyph[2], 20);
    drive_item(4'b1000, hex_glyph[1], 20);
    drive_item(4'h0,    7'h00, 10);

    // 6: reset with three slots seen.
    drive_item(4'b0001, hex_glyph[4], 20);
    drive_item(4'b0010, hex_glyph[3], 20);
    drive_item(4'b0100, hex_glyph[2], 20);
    drive_item(4'h0,    7'h00, 4);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("t6_rst_digits", 32'(digits_o),    32'h0);
    check("t6_rst_err",    32'(err_o),       32'h0);
    check("t6_rst_blank",  32'(blank_o),     32'h0);
    check("t6_rst_fv",     32'(frame_valid), 32'h0);
    check("t6_rst_stale",  32'(stale_o),     32'h1);
    model_reset();
    rst_n = 1'b1;
    drive_item(4'b1000, hex_glyph[1], 20);
    drive_item(4'h0,    7'h00, 20);
    check("t6_partial_digits", 32'(digits_o), 32'h0);
    scan4(1, 2, 3, 4, 20, 4'h0, 2);
    drive_item(4'h0, 7'h00, 10);

    // Random scans: random slots, durations, glyphs, gaps and glitches.
    for (int k = 0; k < 80; k++) begin
      logic [3:0] a;
      logic [6:0] g;
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 15)      a = 4'h0;
      else if (r < 22) a = 4'($urandom_range(0, 15));
      else             a = 4'(1 << $urandom_range(0, 3));
      r = int'($urandom_range(0, 99));
      if (r < 80)      g = hex_glyph[$urandom_range(0, 15)];
      else if (r < 88) g = 7'h00;
      else             g = 7'($urandom_range(0, 127));
      drive_item(a, g, int'($urandom_range(1, 18)));
    end
    drive_item(4'h0, 7'h00, 10);

    wait_cyc = 0;
    while (exp_q.size() != 0 && wait_cyc < 100) begin
      @(negedge clk);
      wait_cyc++;
    end
    check("all_frames_seen", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
